garage_input_conditioner: RTL
=============================

# garage_input_conditioner

Front-end conditioning stage for the automatic garage door controller. Synchronizes and debounces the raw wall-button and the two door limit switches. Drives the controller's `Activate` input with a single-cycle pulse per debounced button press, and its `UP_Max`/`DN_Max` inputs with clean, glitch-free levels. Also flags the physically impossible case where both limit switches read active at the same time.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive clocks a synchronized input must hold a new level before it is accepted (20 ms at 50 MHz). Legal range 2 .. 2^CNT_W−1.
- `CNT_W`, default 20: width of each debounce counter.

Ports:
- `CLK`, in, 1: system clock, 50 MHz, rising-edge.
- `RST`, in, 1: reset. One clock; reset is synchronous and active-high.
- `Btn_Raw`, in, 1: raw wall/remote button, asynchronous, bouncy, 1 = pressed.
- `Up_Lim_Raw`, in, 1: raw open-limit switch, asynchronous, 1 = door fully open.
- `Dn_Lim_Raw`, in, 1: raw closed-limit switch, asynchronous, 1 = door fully closed.
- `Activate`, out, 1: one-cycle pulse per accepted button press; feeds controller `Activate`.
- `UP_Max`, out, 1: debounced open-limit level; feeds controller `UP_Max`.
- `DN_Max`, out, 1: debounced closed-limit level; feeds controller `DN_Max`.
- `Lim_Fault`, out, 1: level, high while `UP_Max` and `DN_Max` are both high.

## Operation
- Three identical channels (button, up-limit, down-limit). Each channel has:
  - a 2-flop synchronizer (`s1`, `s2`);
  - a debounce FSM with a `CNT_W`-bit counter and a stable level `stb`.
- Debounce FSM states: `STABLE_LO`, `PEND_HI`, `STABLE_HI`, `PEND_LO`.
  - `STABLE_LO` → `PEND_HI` when `s2`=1; counter loads 1.
  - `PEND_HI`, `s2`=1, counter < `DEBOUNCE_CYCLES`−1: counter increments, stay.
  - `PEND_HI`, `s2`=1, counter = `DEBOUNCE_CYCLES`−1: go to `STABLE_HI`, `stb`←1, counter←0.
  - `PEND_HI`, `s2`=0: back to `STABLE_LO`, counter←0. Any bounce restarts qualification from zero.
  - `STABLE_HI` and `PEND_LO` mirror the above with polarity inverted.
- Counter never wraps. It is bounded by the `DEBOUNCE_CYCLES`−1 compare.
- `UP_Max` = up-limit `stb`. `DN_Max` = down-limit `stb`. Both are registered.
- `Activate` is registered. It goes high for exactly one cycle following the edge on which the button channel takes the `PEND_HI`→`STABLE_HI` transition.
  - Release (`STABLE_HI`→`STABLE_LO`) produces no pulse.
  - A held button produces exactly one pulse.
- Fault gating:
  - `Lim_Fault` is registered: `Lim_Fault` ← next `UP_Max` AND next `DN_Max`.
  - `Activate` is suppressed (the pulse is dropped, not deferred) if, on the qualifying edge, the next-state limit levels are both 1.
- Simultaneous events:
  - All channels qualify independently.
  - A button qualifying on the same edge as a limit change uses the limits' next-state values for gating.

## Timing
- Reset: on any rising edge with `RST`=1, all synchronizer flops, counters and `stb` clear to 0 and all FSMs go to `STABLE_LO`.
  - Output reset values: `Activate`=0, `UP_Max`=0, `DN_Max`=0, `Lim_Fault`=0.
  - `RST` overrides everything, including a pending qualification or a pulse due on that edge.
- Latency: a raw level first sampled by `s1` at edge k (and held) is reflected in `stb`/`UP_Max`/`DN_Max` after edge k+1+`DEBOUNCE_CYCLES`.
  - `Activate` is high during the cycle after that same edge.
- Reset mid-press: a button still held when `RST` deasserts re-qualifies from zero and yields one `Activate` pulse `DEBOUNCE_CYCLES`+1 edges after the first post-reset sampling edge.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES` clocks at `s2`. Anything shorter is fully rejected.
- Back-to-back presses: minimum spacing between two `Activate` pulses is 2·`DEBOUNCE_CYCLES` clocks (release must qualify in between).

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `CNT_W`=3.
- Reset: drive all raw inputs to 1 with `RST`=1 for 3 edges → all outputs 0 throughout; release `RST` → `UP_Max`=`DN_Max`=1 and `Lim_Fault`=1 after edge 5/6, and no `Activate` pulse.
- Clean press: `Btn_Raw` 0→1 sampled at edge k and held 20 cycles → `Activate`=1 only in the cycle after edge k+5; no further pulse; releasing the button produces no pulse.
- Bounce rejection: `Btn_Raw` toggles 1,0,1,0 with 3-cycle highs, then holds 1 → exactly one `Activate` pulse, 5 edges after the start of the final hold.
- Limit debounce: `Dn_Lim_Raw`=1 held, then a 3-cycle 0 glitch → `DN_Max` rises after edge k+5 and never drops during the glitch; a 4-cycle 0 → `DN_Max` drops.
- Fault gating: `Up_Lim_Raw`=`Dn_Lim_Raw`=1 qualified, then press the button → `Lim_Fault`=1 and no `Activate`; drop `Up_Lim_Raw` (qualified), then press again → one `Activate` pulse.
- Reset mid-qualification: press the button, assert `RST` at count 2, release `RST` with the button still held → no pulse before reset; one pulse 5 edges after the first post-reset sample.

Source files
------------

// File: rtl/garage_input_conditioner.sv
// Garage door front end: synchronizes and debounces the wall button and both
// limit switches, emits one Activate pulse per press, and flags impossible limit states.
module garage_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic Btn_Raw,
  input  logic Up_Lim_Raw,
  input  logic Dn_Lim_Raw,
  output logic Activate,
  output logic UP_Max,
  output logic DN_Max,
  output logic Lim_Fault
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_e;

  localparam int NCH = 3;
  localparam int BTN = 0;
  localparam int UPL = 1;
  localparam int DNL = 2;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [NCH-1:0] rawIn;
  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;
  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0] stb_q;
  logic [NCH-1:0] stb_d;
  logic           activate_q;
  logic           activate_d;
  logic           limFault_q;
  logic           limFault_d;

  assign rawIn = {Dn_Lim_Raw, Up_Lim_Raw, Btn_Raw};

  // State register: synchronizers, debounce FSMs and the registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stb_q      <= '0;
      activate_q <= 1'b0;
      limFault_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= CNT_ZERO;
      end
    end else begin
      s1_q       <= rawIn;
      s2_q       <= s1_q;
      stb_q      <= stb_d;
      activate_q <= activate_d;
      limFault_q <= limFault_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic; any disagreeing sample during a pending state restarts qualification.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      stb_d[i]   = stb_q[i];
      case (state_q[i])
        STABLE_LO: begin
          if (s2_q[i]) begin
            state_d[i] = PEND_HI;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PEND_HI: begin
          if (!s2_q[i]) begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = STABLE_HI;
            stb_d[i]   = 1'b1;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s2_q[i]) begin
            state_d[i] = PEND_LO;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PEND_LO: begin
          if (s2_q[i]) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = STABLE_LO;
            stb_d[i]   = 1'b0;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = STABLE_LO;
          cnt_d[i]   = CNT_ZERO;
          stb_d[i]   = 1'b0;
        end
      endcase
    end
  end

  // Output logic; gating uses next-state limit levels so same-edge limit changes count.
  always_comb begin
    limFault_d = stb_d[UPL] & stb_d[DNL];
    activate_d = (state_q[BTN] == PEND_HI) && (state_d[BTN] == STABLE_HI) && !limFault_d;
  end

  assign Activate  = activate_q;
  assign UP_Max    = stb_q[UPL];
  assign DN_Max    = stb_q[DNL];
  assign Lim_Fault = limFault_q;

endmodule
